// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, coordinate types and sync bundle.
// Also imported by the drawing layers that consume x/y.
package vga_pkg;

   localparam int X_W = 11;
   localparam int Y_W = 10;

   localparam int H_ACTIVE_DEF = 800;
   localparam int H_FP_DEF     = 40;
   localparam int H_SYNC_DEF   = 128;
   localparam int H_BP_DEF     = 88;
   localparam int V_ACTIVE_DEF = 600;
   localparam int V_FP_DEF     = 1;
   localparam int V_SYNC_DEF   = 4;
   localparam int V_BP_DEF     = 23;

   localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF
                          + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF
                          + V_SYNC_DEF + V_BP_DEF;

   typedef logic [X_W-1:0] xcoord_t;
   typedef logic [Y_W-1:0] ycoord_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic active;
   } sync_t;

   function automatic sync_t sync_idle(input logic pol);
      sync_t s;
      s.hsync  = ~pol;
      s.vsync  = ~pol;
      s.active = 1'b0;
      return s;
   endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle from the timing generator to the
// drawing layers and the connector.
interface vga_timing_if;
   import vga_pkg::*;

   xcoord_t x;
   ycoord_t y;
   logic    hsync;
   logic    vsync;
   logic    active;
   logic    line_end;
   logic    frame_start;

   modport master (
      output x, y, hsync, vsync,
      output active, line_end, frame_start
   );

   modport slave (
      input x, y, hsync, vsync,
      input active, line_end, frame_start
   );

endinterface

// File: rtl/vga_sync_delay.sv
// One-clock retiming of hsync/vsync/active so they line up
// with drawing layers that register their pixel data once.
module vga_sync_delay
   import vga_pkg::*;
#(
   parameter bit SYNC_POL = 1'b1
) (
   input  logic  vga_clk,
   input  logic  rst,
   input  sync_t d,
   output sync_t q
);

   always_ff @(posedge vga_clk) begin
      if (rst) begin
         q <= sync_idle(SYNC_POL);
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator; VGA_SYNC_ALIGN_EN adds one clock
// of delay on hsync/vsync/active via vga_sync_delay.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter bit SYNC_POL = 1'b1
) (
   input logic          vga_clk,
   input logic          rst,
   vga_timing_if.master vga
);

   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam xcoord_t H_LAST = xcoord_t'(HT - 1);
   localparam xcoord_t H_VIS  = xcoord_t'(H_ACTIVE);
   localparam xcoord_t HS_BEG = xcoord_t'(H_ACTIVE + H_FP);
   localparam xcoord_t HS_END =
      xcoord_t'(H_ACTIVE + H_FP + H_SYNC - 1);

   localparam ycoord_t V_LAST = ycoord_t'(VT - 1);
   localparam ycoord_t V_VIS  = ycoord_t'(V_ACTIVE);
   localparam ycoord_t VS_BEG = ycoord_t'(V_ACTIVE + V_FP);
   localparam ycoord_t VS_END =
      ycoord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

   xcoord_t x_q, x_nxt;
   ycoord_t y_q, y_nxt;
   sync_t   sync_q, sync_nxt, sync_o;
   logic    line_end_q, line_end_nxt;
   logic    frame_start_q, frame_start_nxt;
   logic    x_wrap;

   always_comb begin
      x_wrap = (x_q == H_LAST);
      x_nxt  = x_wrap ? '0 : x_q + 1'b1;
      y_nxt  = y_q;
      if (x_wrap) begin
         y_nxt = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end
   end

   // Flags decode the upcoming count so they land with x/y.
   always_comb begin
      sync_nxt        = sync_idle(SYNC_POL);
      sync_nxt.active = (x_nxt < H_VIS) && (y_nxt < V_VIS);
      if (x_nxt >= HS_BEG && x_nxt <= HS_END) begin
         sync_nxt.hsync = SYNC_POL;
      end
      if (y_nxt >= VS_BEG && y_nxt <= VS_END) begin
         sync_nxt.vsync = SYNC_POL;
      end
      line_end_nxt    = (x_nxt == H_LAST);
      frame_start_nxt = (x_nxt == '0) && (y_nxt == '0);
   end

   always_ff @(posedge vga_clk) begin
      if (rst) begin
         x_q           <= H_LAST;
         y_q           <= V_LAST;
         sync_q        <= sync_idle(SYNC_POL);
         line_end_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         x_q           <= x_nxt;
         y_q           <= y_nxt;
         sync_q        <= sync_nxt;
         line_end_q    <= line_end_nxt;
         frame_start_q <= frame_start_nxt;
      end
   end

`ifdef VGA_SYNC_ALIGN_EN
   vga_sync_delay #(
      .SYNC_POL (SYNC_POL)
   ) u_sync_delay (
      .vga_clk (vga_clk),
      .rst     (rst),
      .d       (sync_q),
      .q       (sync_o)
   );
`else
   assign sync_o = sync_q;
`endif

   assign vga.x           = x_q;
   assign vga.y           = y_q;
   assign vga.hsync       = sync_o.hsync;
   assign vga.vsync       = sync_o.vsync;
   assign vga.active      = sync_o.active;
   assign vga.line_end    = line_end_q;
   assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default-size instance for line checks,
// a small inverted-polarity instance for frame-level checks.
module tb_vga_timing;
   import vga_pkg::*;

`ifdef VGA_SYNC_ALIGN_EN
   localparam bit ALN = 1'b1;
`else
   localparam bit ALN = 1'b0;
`endif

   localparam int AH = 1056;
   localparam int BH = 24;
   localparam int BV = 12;
   localparam int BF = BH * BV;

   logic vga_clk = 1'b0;
   logic rst_a   = 1'b1;
   logic rst_b   = 1'b1;

   always #5 vga_clk = ~vga_clk;

   vga_timing_if va();
   vga_timing_if vb();

   vga_timing u_a (
      .vga_clk (vga_clk),
      .rst     (rst_a),
      .vga     (va)
   );

   vga_timing #(
      .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
      .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (1),
      .SYNC_POL (1'b0)
   ) u_b (
      .vga_clk (vga_clk),
      .rst     (rst_b),
      .vga     (vb)
   );

   typedef struct {
      int   tx;
      int   ty;
      logic act;
      logic hs;
      logic vs;
      logic le;
      logic fs;
   } vec_t;

   vec_t tab [12];
   int n_chk = 0;
   int n_err = 0;
   int ax, ay;

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic a_step();
      tick();
      ax++;
      if (ax == AH) begin
         ax = 0;
         ay++;
      end
   endtask

   function automatic logic [4:0] a_flags();
      return {va.active, va.hsync, va.vsync,
              va.line_end, va.frame_start};
   endfunction

   function automatic logic [4:0] b_flags();
      return {vb.active, vb.hsync, vb.vsync,
              vb.line_end, vb.frame_start};
   endfunction

   initial begin
      int t, hs_cnt, hs_first, hs_last;
      int vs_cnt, fs_first, fs_second;
      int bx, by;
      logic c_act, c_hs, c_vs;
      logic p_act, p_hs, p_vs;
      logic [25:0] got, exp;

      tab[0]  = '{0,    0,  !ALN, 0, 0, 0, 1};
      tab[1]  = '{1,    0,  1,    0, 0, 0, 0};
      tab[2]  = '{799,  10, 1,    0, 0, 0, 0};
      tab[3]  = '{800,  10, ALN,  0, 0, 0, 0};
      tab[4]  = '{801,  10, 0,    0, 0, 0, 0};
      tab[5]  = '{839,  10, 0,    0, 0, 0, 0};
      tab[6]  = '{840,  10, 0,    !ALN, 0, 0, 0};
      tab[7]  = '{841,  10, 0,    1, 0, 0, 0};
      tab[8]  = '{967,  10, 0,    1, 0, 0, 0};
      tab[9]  = '{968,  10, 0,    ALN, 0, 0, 0};
      tab[10] = '{1055, 10, 0,    0, 0, 1, 0};
      tab[11] = '{0,    11, !ALN, 0, 0, 0, 0};

      repeat (3) tick();
      chk("a_rst_x", 32'(va.x), 1055);
      chk("a_rst_y", 32'(va.y), 627);
      chk("a_rst_flags", 32'(a_flags()), 0);
      chk("b_rst_x", 32'(vb.x), 23);
      chk("b_rst_y", 32'(vb.y), 11);
      chk("b_rst_flags", 32'(b_flags()), 32'b01100);

      rst_a = 1'b0;
      tick();
      ax = 0;
      ay = 0;
      for (int i = 0; i < 12; i++) begin
         t = tab[i].ty * AH + tab[i].tx;
         if (t < ay * AH + ax) begin
            chk($sformatf("a_tab%0d_order", i), 0, 1);
         end
         while (ay * AH + ax < t) a_step();
         chk($sformatf("a_tab%0d_x", i), 32'(va.x), tab[i].tx);
         chk($sformatf("a_tab%0d_y", i), 32'(va.y), tab[i].ty);
         chk($sformatf("a_tab%0d_flags", i), 32'(a_flags()),
             32'({tab[i].act, tab[i].hs, tab[i].vs,
                  tab[i].le, tab[i].fs}));
      end

      hs_cnt = 0;
      hs_first = -1;
      hs_last = -1;
      for (int i = 0; i < AH; i++) begin
         if (va.hsync) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(va.x);
            hs_last = int'(va.x);
         end
         a_step();
      end
      chk("a_hs_width", hs_cnt, 128);
      chk("a_hs_first", hs_first, 840 + int'(ALN));
      chk("a_hs_last", hs_last, 967 + int'(ALN));
      chk("a_line_x", 32'(va.x), 0);
      chk("a_line_y", 32'(va.y), 12);

      while (ax < 500) a_step();
      chk("a_pre_rst_x", 32'(va.x), 500);
      rst_a = 1'b1;
      tick();
      chk("a_mid_rst_x", 32'(va.x), 1055);
      chk("a_mid_rst_y", 32'(va.y), 627);
      chk("a_mid_rst_flags", 32'(a_flags()), 0);
      rst_a = 1'b0;
      tick();
      chk("a_rel_x", 32'(va.x), 0);
      chk("a_rel_y", 32'(va.y), 0);
      chk("a_rel_fs", 32'(va.frame_start), 1);

      rst_b = 1'b0;
      tick();
      bx = 0;
      by = 0;
      p_act = 1'b0;
      p_hs = 1'b1;
      p_vs = 1'b1;
      hs_cnt = 0;
      vs_cnt = 0;
      fs_first = -1;
      fs_second = -1;
      for (int i = 0; i < 2 * BF + 4; i++) begin
         c_act = (bx < 16) && (by < 8);
         c_hs  = !(bx >= 18 && bx <= 21);
         c_vs  = !(by >= 9 && by <= 10);
         exp = {11'(bx), 10'(by),
                ALN ? p_hs : c_hs,
                ALN ? p_vs : c_vs,
                ALN ? p_act : c_act,
                logic'(bx == 23),
                logic'(bx == 0 && by == 0)};
         got = {vb.x, vb.y, vb.hsync, vb.vsync,
                vb.active, vb.line_end, vb.frame_start};
         chk($sformatf("b_cycle%0d", i), 32'(got), 32'(exp));
         if (i < BF && !vb.hsync) hs_cnt++;
         if (i < BF && !vb.vsync) vs_cnt++;
         if (vb.frame_start) begin
            if (fs_first < 0) fs_first = i;
            else if (fs_second < 0) fs_second = i;
         end
         p_act = c_act;
         p_hs = c_hs;
         p_vs = c_vs;
         tick();
         bx++;
         if (bx == BH) begin
            bx = 0;
            by = (by == BV - 1) ? 0 : by + 1;
         end
      end
      chk("b_hs_frame", hs_cnt, 4 * BV);
      chk("b_vs_frame", vs_cnt, 2 * BH);
      chk("b_fs_first", fs_first, 0);
      chk("b_fs_period", fs_second - fs_first, BF);

      repeat (BF - 1 - 4) tick();
      chk("b_last_x", 32'(vb.x), 23);
      chk("b_last_y", 32'(vb.y), 11);
      chk("b_last_le", 32'(vb.line_end), 1);
      tick();
      chk("b_wrap_x", 32'(vb.x), 0);
      chk("b_wrap_y", 32'(vb.y), 0);
      chk("b_wrap_fs", 32'(vb.frame_start), 1);

      repeat (6 * BH + 12) tick();
      chk("b_pre_rst_x", 32'(vb.x), 12);
      chk("b_pre_rst_y", 32'(vb.y), 6);
      rst_b = 1'b1;
      tick();
      chk("b_mid_rst_x", 32'(vb.x), 23);
      chk("b_mid_rst_y", 32'(vb.y), 11);
      chk("b_mid_rst_flags", 32'(b_flags()), 32'b01100);
      rst_b = 1'b0;
      tick();
      chk("b_rel_x", 32'(vb.x), 0);
      chk("b_rel_y", 32'(vb.y), 0);
      chk("b_rel_flags", 32'(b_flags()),
          32'({!ALN, 1'b1, 1'b1, 1'b0, 1'b1}));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
- REQ-001 The block SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
- REQ-002 The block SHALL have parameter H_FP, default 40, horizontal front porch in clocks.
- REQ-003 The block SHALL have parameter H_SYNC, default 128, horizontal sync width in clocks.
- REQ-004 The block SHALL have parameter H_BP, default 88, horizontal back porch; line total is 1056.
- REQ-005 The block SHALL have parameter V_ACTIVE, default 600, visible lines per frame.
- REQ-006 The block SHALL have parameter V_FP, default 1, vertical front porch in lines.
- REQ-007 The block SHALL have parameter V_SYNC, default 4, vertical sync width in lines.
- REQ-008 The block SHALL have parameter V_BP, default 23, vertical back porch; frame total is 628.
- REQ-009 The block SHALL have parameter SYNC_POL, default 1, asserted sync level (1 = active-high).
- REQ-010 The block SHALL have port vga_clk, input, 1 bit, the single pixel clock (40 MHz for defaults).
- REQ-011 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
- REQ-012 The block SHALL have port x, output, 11 bits, current horizontal count.
- REQ-013 The block SHALL have port y, output, 10 bits, current vertical count.
- REQ-014 The block SHALL have port hsync, output, 1 bit, horizontal sync to the connector.
- REQ-015 The block SHALL have port vsync, output, 1 bit, vertical sync to the connector.
- REQ-016 The block SHALL have port active, output, 1 bit, high while x,y is in the visible area.
- REQ-017 The block SHALL have port line_end, output, 1 bit, one-clock pulse on the last clock of each line.
- REQ-018 The block SHALL have port frame_start, output, 1 bit, one-clock pulse at x=0, y=0.

Function
- REQ-019 x SHALL increment by 1 every vga_clk and wrap from H_TOTAL-1 (1055) to 0.
- REQ-020 y SHALL increment by 1 only on the cycle x wraps, and wrap from V_TOTAL-1 (627) to 0 on that same cycle.
- REQ-021 active SHALL be 1 exactly when x < H_ACTIVE and y < V_ACTIVE; registered, aligned with the x,y presented in the same cycle.
- REQ-022 hsync SHALL be at SYNC_POL level exactly when x is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (840..967 by default), otherwise the opposite level.
- REQ-023 vsync SHALL be at SYNC_POL level exactly when y is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (601..604 by default), for the full line.
- REQ-024 line_end SHALL be 1 exactly when x = 1055; frame_start SHALL be 1 exactly when x=0 and y=0.
- REQ-025 All outputs SHALL be driven from flops; there is no combinational path from any input to any output.
- REQ-026 Sync and flag outputs SHALL be decoded from the next-count value so they are coincident with x,y (zero relative latency).
- REQ-027 Counter widths SHALL be fixed at 11/10 bits; parameter sets with H_TOTAL > 2048 or V_TOTAL > 1024 are unsupported.

Reset
- REQ-028 While rst=1: x=1055, y=627, active=0, line_end=0, frame_start=0, hsync and vsync at the inactive level.
- REQ-029 The first clock after rst falls SHALL present x=0, y=0, active=1, frame_start=1.
- REQ-030 rst asserted mid-frame SHALL take effect on the next edge, with no partial-line completion.

Configuration
- REQ-031 Macro VGA_SYNC_ALIGN_EN, when defined, SHALL delay hsync, vsync and active by one extra vga_clk (x, y, line_end and frame_start unchanged) to match the one-clock latency of the registered drawing layers.
- REQ-032 When VGA_SYNC_ALIGN_EN is undefined, hsync, vsync and active SHALL be coincident with x,y per REQ-026.
- REQ-033 With the macro defined, the delay flops SHALL reset to inactive sync and active=0.

Structure
- REQ-034 The timing defaults, H_TOTAL/V_TOTAL and the coordinate widths SHALL live in the shared package vga_pkg, which the drawing layers also import.
- REQ-035 The optional delay stage SHALL be the sub-module vga_sync_delay, instantiated only under VGA_SYNC_ALIGN_EN.

Verification
- REQ-036 Release rst -> first cycle x=0, y=0, frame_start=1, active=1; frame_start recurs exactly 1056*628 = 663168 clocks later.
- REQ-037 Sample at x=799 then x=800 on y=10 -> active goes 1 then 0; at x=1055, line_end=1, and the next cycle is x=0, y=11.
- REQ-038 Scan one line -> hsync is asserted for exactly 128 clocks, x=840..967, with SYNC_POL=1; rerun with SYNC_POL=0 -> the levels are inverted.
- REQ-039 Scan one frame -> vsync is asserted for exactly 4*1056 clocks, y=601..604; at x=1055, y=627 the next cycle is x=0, y=0.
- REQ-040 Assert rst at x=500, y=300 -> next cycle x=1055, y=627, all flags 0; after release, x=0, y=0.
- REQ-041 With VGA_SYNC_ALIGN_EN defined -> hsync rises at x=841 and active falls at x=801, each one clock later than without the macro.
